// File: rtl/lbus_pkg.sv
// Shared types and widths for the PL local-bus arbiter.
package lbus_pkg;

    localparam int LBUS_AW = 16;
    localparam int LBUS_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } lbus_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: search starts one past the last winner.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] winner
);
    localparam int IW = $clog2(NREQ);

    int            idx;
    logic [IW-1:0] idx_w;

    // Walk offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx   = (int'(last) + off) % NREQ;
            idx_w = IW'(idx);
            if (req[idx_w]) begin
                valid  = 1'b1;
                winner = idx_w;
            end
        end
    end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter serialising N requesters onto the 16-bit PL local bus.
//
// state     | meaning
// ST_IDLE   | arbitrate pending requests, latch winner's bus fields
// ST_STROBE | single-cycle bstrobe on the bus, load read-latency counter
// ST_WAIT   | count down bus latency, capture brddata on terminal count
// ST_ACK    | one-cycle ack to the winner, remember it for round-robin
module lbus_arbiter
    import lbus_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic                      plclk,
    input  logic                      aresetn,
    input  logic [NREQ-1:0]           req,
    input  logic [LBUS_AW*NREQ-1:0]   req_addr,
    input  logic [LBUS_DW*NREQ-1:0]   req_wrdata,
    input  logic [NREQ-1:0]           req_wr,
    output logic [NREQ-1:0]           ack,
    output logic [LBUS_DW-1:0]        rddata,
    output logic [LBUS_AW-1:0]        baddr,
    output logic [LBUS_DW-1:0]        bwrdata,
    output logic                      bwr,
    output logic                      bstrobe,
    input  logic [LBUS_DW-1:0]        brddata,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   gnt_id
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = 3;

    lbus_state_e        state;
    logic [IW-1:0]      last_gnt;
    logic [CW-1:0]      wait_cnt;
    logic               pick_valid;
    logic [IW-1:0]      pick_id;
    logic [LBUS_AW-1:0] addr_arr  [NREQ];
    logic [LBUS_DW-1:0] wdata_arr [NREQ];
    logic [NREQ-1:0]    gnt_onehot;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (req),
        .last   (last_gnt),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*LBUS_AW +: LBUS_AW];
            wdata_arr[i] = req_wrdata[i*LBUS_DW +: LBUS_DW];
        end
    end

    always_comb begin
        gnt_onehot         = '0;
        gnt_onehot[gnt_id] = 1'b1;
    end

    always_ff @(posedge plclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            ack      <= '0;
            rddata   <= '0;
            baddr    <= '0;
            bwrdata  <= '0;
            bwr      <= 1'b0;
            bstrobe  <= 1'b0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            last_gnt <= IW'(NREQ - 1);
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        baddr   <= addr_arr[pick_id];
                        bwrdata <= wdata_arr[pick_id];
                        bwr     <= req_wr[pick_id];
                        gnt_id  <= pick_id;
                        bstrobe <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    bstrobe  <= 1'b0;
                    wait_cnt <= CW'(RD_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Writes run the same latency so every transaction has a fixed period.
                    if (wait_cnt == '0) begin
                        if (!bwr) begin
                            rddata <= brddata;
                        end
                        ack   <= gnt_onehot;
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    ack      <= '0;
                    busy     <= 1'b0;
                    last_gnt <= gnt_id;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbus_arbiter.sv
// Directed bench: instance A at RD_LAT=1 with a small LED slave, instance B at RD_LAT=3.
module tb_lbus_arbiter;

    logic        plclk = 1'b0;
    logic        aresetn;

    logic [1:0]  req_a, req_wr_a, ack_a;
    logic [31:0] req_addr_a, req_wrdata_a;
    logic [15:0] rddata_a, baddr_a, bwrdata_a, brddata_a, rd_val_a, led_reg;
    logic        bwr_a, bstrobe_a, busy_a;
    logic [0:0]  gnt_id_a;

    logic [1:0]  req_b, req_wr_b, ack_b;
    logic [31:0] req_addr_b, req_wrdata_b;
    logic [15:0] rddata_b, baddr_b, bwrdata_b, brddata_b;
    logic        bwr_b, bstrobe_b, busy_b;
    logic [0:0]  gnt_id_b;

    int n_chk = 0;
    int n_err = 0;
    int strobe_cnt_a = 0, strobe_cnt_b = 0, ack_cnt_a = 0;
    int ack_multi_a = 0, ack_multi_b = 0;

    always #5 plclk = ~plclk;

    lbus_arbiter #(.NREQ(2), .RD_LAT(1)) u_dut_a (
        .plclk(plclk), .aresetn(aresetn), .req(req_a), .req_addr(req_addr_a),
        .req_wrdata(req_wrdata_a), .req_wr(req_wr_a), .ack(ack_a), .rddata(rddata_a),
        .baddr(baddr_a), .bwrdata(bwrdata_a), .bwr(bwr_a), .bstrobe(bstrobe_a),
        .brddata(brddata_a), .busy(busy_a), .gnt_id(gnt_id_a)
    );

    lbus_arbiter #(.NREQ(2), .RD_LAT(3)) u_dut_b (
        .plclk(plclk), .aresetn(aresetn), .req(req_b), .req_addr(req_addr_b),
        .req_wrdata(req_wrdata_b), .req_wr(req_wr_b), .ack(ack_b), .rddata(rddata_b),
        .baddr(baddr_b), .bwrdata(bwrdata_b), .bwr(bwr_b), .bstrobe(bstrobe_b),
        .brddata(brddata_b), .busy(busy_b), .gnt_id(gnt_id_b)
    );

    // LED slave at address 0x0002 holds the low byte; other addresses return rd_val_a.
    assign brddata_a = (baddr_a == 16'h0002) ? led_reg : rd_val_a;

    always @(posedge plclk or negedge aresetn) begin
        if (!aresetn)
            led_reg <= 16'h0000;
        else if (bstrobe_a && bwr_a && baddr_a == 16'h0002)
            led_reg <= {8'h00, bwrdata_a[7:0]};
    end

    always @(posedge plclk) begin
        if (bstrobe_a) strobe_cnt_a++;
        if (bstrobe_b) strobe_cnt_b++;
        if (|ack_a) ack_cnt_a++;
        if ($countones(ack_a) > 1) ack_multi_a++;
        if ($countones(ack_b) > 1) ack_multi_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge plclk);
        #1;
    endtask

    // One isolated transaction on instance A; called from an IDLE cycle.
    task automatic xact_a(input int i, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic wr, input logic [15:0] exp_rd);
        req_addr_a[16*i +: 16]   = addr;
        req_wrdata_a[16*i +: 16] = wdata;
        req_wr_a[i]              = wr;
        req_a[i]                 = 1'b1;
        cyc();
        chk("xa_strobe", bstrobe_a, 1);
        chk("xa_baddr", baddr_a, addr);
        chk("xa_bwr", bwr_a, wr);
        chk("xa_gnt", gnt_id_a, i);
        chk("xa_busy", busy_a, 1);
        if (wr) chk("xa_bwrdata", bwrdata_a, wdata);
        cyc();
        chk("xa_strobe_off", bstrobe_a, 0);
        chk("xa_ack_early", ack_a, 0);
        cyc();
        chk("xa_ack", ack_a, 2'b01 << i);
        chk("xa_rddata", rddata_a, exp_rd);
        chk("xa_busy_ack", busy_a, 1);
        req_a[i] = 1'b0;
        cyc();
        chk("xa_ack_off", ack_a, 0);
        chk("xa_busy_off", busy_a, 0);
    endtask

    initial begin
        int s0, a0;
        aresetn = 1'b0;
        req_a = '0; req_wr_a = '0; req_addr_a = '0; req_wrdata_a = '0; rd_val_a = 16'hBEEF;
        req_b = '0; req_wr_b = '0; req_addr_b = '0; req_wrdata_b = '0; brddata_b = '0;
        cyc();
        cyc();
        chk("rst_ack", ack_a, 0);
        chk("rst_strobe", bstrobe_a, 0);
        chk("rst_bus", {baddr_a, bwrdata_a}, 0);
        chk("rst_misc", {rddata_a, bwr_a, busy_a, gnt_id_a}, 0);
        aresetn = 1'b1;
        cyc();

        // single read, write, LED readback
        xact_a(0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
        xact_a(1, 16'h0002, 16'h00A5, 1'b1, 16'hBEEF);
        xact_a(1, 16'h0002, 16'h0000, 1'b0, 16'h00A5);

        // contention: last winner was 1, so grants run 0,1,0,1
        req_addr_a = {16'h0200, 16'h0100};
        req_wr_a   = 2'b00;
        req_a      = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("cont_strobe", bstrobe_a, (k % 4) == 1);
            if (k % 4 == 1) begin
                chk("cont_gnt", gnt_id_a, ((k - 1) / 4) % 2);
                chk("cont_baddr", baddr_a, (((k - 1) / 4) % 2) ? 16'h0200 : 16'h0100);
            end
            if (k % 4 == 3) chk("cont_ack", ack_a, 2'b01 << (((k - 3) / 4) % 2));
            if (k == 15) req_a = 2'b00;
        end

        // RD_LAT=3 read: wrong data until cycle 4
        brddata_b              = 16'hDEAD;
        req_addr_b[15:0]       = 16'h0030;
        req_b                  = 2'b01;
        cyc();
        chk("b_strobe", bstrobe_b, 1);
        chk("b_baddr", baddr_b, 16'h0030);
        cyc();
        chk("b_ack_c2", ack_b, 0);
        cyc();
        chk("b_ack_c3", ack_b, 0);
        cyc();
        chk("b_ack_c4", ack_b, 0);
        brddata_b = 16'h1234;
        cyc();
        chk("b_ack_c5", ack_b, 2'b01);
        chk("b_rddata", rddata_b, 16'h1234);
        req_b     = 2'b00;
        brddata_b = 16'h5555;
        cyc();
        chk("b_ack_c6", ack_b, 0);
        chk("b_rddata_hold", rddata_b, 16'h1234);

        // request withdrawn during WAIT still completes with one strobe
        s0                = strobe_cnt_b;
        brddata_b         = 16'h2222;
        req_addr_b[31:16] = 16'h0040;
        req_b             = 2'b10;
        cyc();
        chk("wd_strobe", bstrobe_b, 1);
        chk("wd_gnt", gnt_id_b, 1);
        cyc();
        req_b = 2'b00;
        cyc();
        cyc();
        cyc();
        chk("wd_ack", ack_b, 2'b10);
        chk("wd_rddata", rddata_b, 16'h2222);
        cyc();
        cyc();
        chk("wd_strobes", strobe_cnt_b - s0, 1);

        // reset mid-transaction; last winner 0 before, so requester 0 must win only via reset
        rd_val_a = 16'h7777;
        xact_a(0, 16'h0050, 16'h0000, 1'b0, 16'h7777);
        req_addr_a[31:16] = 16'h0060;
        req_a             = 2'b10;
        cyc();
        chk("ab_strobe", bstrobe_a, 1);
        chk("ab_gnt", gnt_id_a, 1);
        cyc();
        aresetn = 1'b0;
        #1;
        chk("ab_rst_bus", {baddr_a, bwrdata_a, bwr_a, bstrobe_a}, 0);
        chk("ab_rst_ctl", {ack_a, busy_a, gnt_id_a}, 0);
        chk("ab_rst_rddata", rddata_a, 0);
        req_a = 2'b00;
        cyc();
        cyc();
        aresetn = 1'b1;
        s0 = strobe_cnt_a;
        a0 = ack_cnt_a;
        repeat (4) cyc();
        chk("ab_no_strobe", strobe_cnt_a - s0, 0);
        chk("ab_no_ack", ack_cnt_a - a0, 0);
        req_addr_a = {16'h0080, 16'h0070};
        req_a      = 2'b11;
        cyc();
        chk("ab_restart_strobe", bstrobe_a, 1);
        chk("ab_restart_gnt", gnt_id_a, 0);
        chk("ab_restart_baddr", baddr_a, 16'h0070);
        cyc();
        cyc();
        chk("ab_restart_ack", ack_a, 2'b01);
        req_a = 2'b00;
        cyc();
        cyc();

        chk("onehot_ack_a", ack_multi_a, 0);
        chk("onehot_ack_b", ack_multi_b, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lbus_arbiter.md
# lbus_arbiter

Round-robin arbiter that shares the 16-bit PL local bus (baddr/bwrdata/brddata/bwr/bstrobe) between N requesters, e.g. the AXI-lite bridge and on-chip sequencers. It serialises transactions, issues one single-cycle bstrobe per grant, captures read data after a fixed bus latency and returns a one-cycle ack to the winner. It sits between the requesters and the register-file slaves such as the LED/control block, all in the plclk domain.

## Interface
- NREQ, 2, number of requesters (2..4)
- RD_LAT, 1, cycles from bstrobe to valid brddata (1..7)
- plclk  in  1  PL clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request, level
- req_addr  in  16*NREQ  flattened addresses, requester i at [16i+15:16i]
- req_wrdata  in  16*NREQ  flattened write data
- req_wr  in  NREQ  1 = write, 0 = read
- ack  out  NREQ  one-cycle completion pulse, at most one bit set
- rddata  out  16  captured read data, valid while ack is high
- baddr  out  16  bus address
- bwrdata  out  16  bus write data
- bwr  out  1  bus write qualifier
- bstrobe  out  1  one-cycle bus strobe
- brddata  in  16  bus read data
- busy  out  1  high from grant until ack cycle inclusive
- gnt_id  out  clog2(NREQ)  index of current/last granted requester

## Operation
- FSM: IDLE, STROBE, WAIT, ACK.
- IDLE: if any req bit high, pick winner by round-robin starting at (last_gnt+1) mod NREQ; latch its addr, wrdata, wr into baddr/bwrdata/bwr; gnt_id <= winner; -> STROBE. No req: stay.
- STROBE: bstrobe=1 for exactly this cycle; load wait counter with RD_LAT-1; -> WAIT.
- WAIT: decrement; when counter is 0, rddata <= brddata (reads only; writes leave rddata unchanged); -> ACK.
- ACK: ack[gnt_id]=1; last_gnt <= gnt_id; -> IDLE.
- Reads and writes take identical time.
- baddr/bwrdata/bwr held stable from STROBE through ACK; change only on next grant.
- Requester must hold addr/wrdata/wr stable while req high until its ack. Req dropping mid-transaction is ignored: the bus cycle completes and ack still pulses.
- req still high in cycle after ack = new request, arbitrated normally (other pending requesters win first).
- Simultaneous requests: round-robin guarantees each pending requester granted within NREQ transactions.
- After reset last_gnt = NREQ-1, so requester 0 has first priority.

## Timing
- Reset (async assert, sync release): state IDLE, ack=0, bstrobe=0, bwr=0, baddr=0, bwrdata=0, rddata=0, busy=0, gnt_id=0. Reset mid-transaction aborts it: no ack, no further strobe.
- All outputs registered.
- req sampled in IDLE in cycle 0 -> bstrobe cycle 1 -> brddata captured at end of cycle 1+RD_LAT -> ack cycle 2+RD_LAT.
- Transaction period 3+RD_LAT cycles (4 at RD_LAT=1); back-to-back grants have one IDLE cycle between ack and next strobe-setup.
- busy high cycles 1..2+RD_LAT.

## Structure
- Package lbus_pkg: state enum (IDLE, STROBE, WAIT, ACK), LBUS_AW=16, LBUS_DW=16 constants.
- Sub-module rr_pick: combinational round-robin picker (req vector, last index -> valid, winner index).
- Top holds FSM, wait counter, latched bus fields, rddata register.

## Test plan
- Single read, NREQ=2, RD_LAT=1: req[0]=1, addr 0x0010, slave returns 0xBEEF -> bstrobe cycle 1 with baddr 0x0010, bwr 0, ack[0] cycle 3, rddata 0xBEEF.
- Single write: req[1], addr 0x0002, wrdata 0x00A5 -> one bstrobe, bwr 1, bwrdata 0x00A5, ack[1] cycle 3, rddata unchanged; LED slave reads back 0xA5.
- Contention: req[0] and req[1] held high for 4 transactions -> grants 0,1,0,1; strobes every 4 cycles; never two ack bits.
- RD_LAT=3: read -> ack cycle 5; brddata changed to wrong value before cycle 4 is not captured.
- Req withdrawn in WAIT -> transaction completes, ack pulses, exactly one strobe.
- aresetn low in WAIT -> all outputs zero immediately, no ack after release; next req[0] starts cleanly from IDLE with requester 0 first.
